instr_fetch_requester: RTL and testbench

- CPU-side initiator for instruction reads on the memory bus. It is the request end of the interface whose data/waitrequest end is consumed by the instruction-capture stage.
- Accepts a fetch address from the PC stage and drives an Avalon-style read (address/read/byteenable, held while waitrequest).
- Captures readdata and presents it to the CPU with a valid/ready handshake.
- Supports pipeline flush (branch/jump redirect) without violating bus rules.

---
 rtl/instr_fetch_requester_if.sv | 28 ++
 rtl/instr_fetch_requester.sv | 100 ++++++++++
 tb/tb_instr_fetch_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_requester_if.sv
// Avalon-style instruction read bus between the fetch requester (master)
// and the instruction memory / capture side (slave).
interface instr_fetch_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [3:0]        mem_byteenable;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    output mem_byteenable,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_byteenable,
    output mem_waitrequest,
    output mem_readdata
  );
endinterface

// File: rtl/instr_fetch_requester.sv
// Instruction fetch initiator: turns PC-stage requests into single Avalon reads
// and returns the instruction (or a misalignment fault) over a valid/ready port.
module instr_fetch_requester #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  input  logic                    flush,
  output logic                    cpu_rsp_valid,
  input  logic                    cpu_rsp_ready,
  output logic [DATA_W-1:0]       cpu_rsp_data,
  output logic                    cpu_rsp_err,
  instr_fetch_requester_if.master bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        stall_count
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              req_fire;
  logic              misaligned;
  logic              rd_done;
  logic              stalled;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign misaligned    = cpu_req_addr[1:0] != 2'b00;
  assign cpu_req_ready = !flush && (state == IDLE || (state == RESP && cpu_rsp_ready));
  assign req_fire      = cpu_req_valid && cpu_req_ready;

  assign bus.mem_read       = (state == REQ) || (state == DRAIN);
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = bus.mem_read ? 4'hF : 4'h0;
  assign rd_done            = bus.mem_read && !bus.mem_waitrequest;
  assign stalled            = bus.mem_read && bus.mem_waitrequest;

  assign cpu_rsp_valid = (state == RESP);
  assign cpu_rsp_data  = data_q;
  assign cpu_rsp_err   = err_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) state_nxt = misaligned ? RESP : REQ;
      end
      REQ: begin
        if (!bus.mem_waitrequest) state_nxt = flush ? IDLE : RESP;
        else if (flush)           state_nxt = DRAIN;
      end
      // A started bus read cannot be withdrawn; wait it out and drop the data.
      DRAIN: begin
        if (!bus.mem_waitrequest) state_nxt = IDLE;
      end
      RESP: begin
        if (flush)              state_nxt = IDLE;
        else if (req_fire)      state_nxt = misaligned ? RESP : REQ;
        else if (cpu_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      stall_count <= '0;
    end else begin
      if (req_fire && !misaligned) addr_q <= cpu_req_addr;
      if (req_fire && misaligned) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end else if (state == REQ && rd_done && !flush) begin
        data_q <= bus.mem_readdata;
        err_q  <= 1'b0;
      end
      if (stalled) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_instr_fetch_requester.sv
// Self-checking bench for instr_fetch_requester: directed scenarios plus a
// randomized transaction-level comparison against a behavioural model.
module tb_instr_fetch_requester;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_addr;
  logic          flush;
  logic          cpu_rsp_valid;
  logic          cpu_rsp_ready;
  logic [DW-1:0] cpu_rsp_data;
  logic          cpu_rsp_err;
  logic          busy;
  logic [CW-1:0] stall_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_stall  = 0;

  instr_fetch_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_requester #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .flush         (flush),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_ready (cpu_rsp_ready),
    .cpu_rsp_data  (cpu_rsp_data),
    .cpu_rsp_err   (cpu_rsp_err),
    .bus           (bus.master),
    .busy          (busy),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the random test: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int sat_add(input int s, input int n);
    return (s + n > SAT) ? SAT : s + n;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_addr = '0; flush = 1'b0;
    cpu_rsp_ready = 1'b0; bus.mem_waitrequest = 1'b0; bus.mem_readdata = '0;
    #3;
    compared++;
    if ({bus.mem_read, bus.mem_byteenable, bus.mem_address} !== 37'h0) begin
      mismatched++; $display("FAIL reset_bus: got %h want 0", {bus.mem_read, bus.mem_byteenable, bus.mem_address});
    end
    compared++;
    if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, stall_count, busy} !== '0) begin
      mismatched++; $display("FAIL reset_rsp: valid=%b err=%b data=%h stall=%0d busy=%b want all 0",
                             cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, stall_count, busy);
    end
    compared++;
    if (cpu_req_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_ready: got %b want 1", cpu_req_ready);
    end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h40;
    bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'h8C22_0004;
    #1;
    compared++;
    if (cpu_req_ready !== 1'b1) begin mismatched++; $display("FAIL zw_req_ready: got %b want 1", cpu_req_ready); end
    step();
    cpu_req_valid = 1'b0;
    compared++;
    if ({bus.mem_read, bus.mem_address, bus.mem_byteenable, cpu_rsp_valid} !== {1'b1, 32'h40, 4'hF, 1'b0}) begin
      mismatched++; $display("FAIL zw_bus: read=%b addr=%h be=%h rsp_valid=%b want 1/40/f/0",
                             bus.mem_read, bus.mem_address, bus.mem_byteenable, cpu_rsp_valid);
    end
    step();
    compared++;
    if ({bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data} !== {1'b0, 1'b1, 1'b0, 32'h8C22_0004}) begin
      mismatched++; $display("FAIL zw_rsp: read=%b valid=%b err=%b data=%h want 0/1/0/8c220004",
                             bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data);
    end
    compared++;
    if (stall_count !== CW'(exp_stall)) begin mismatched++; $display("FAIL zw_stall: got %0d want %0d", stall_count, exp_stall); end
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
    compared++;
    if ({cpu_rsp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL zw_done: valid=%b busy=%b want 0/0", cpu_rsp_valid, busy); end
  endtask

  task automatic test_wait_states();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h100;
    bus.mem_waitrequest = 1'b1; bus.mem_readdata = 32'hFFFF_0000;
    step();
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({bus.mem_read, bus.mem_address, bus.mem_byteenable} !== {1'b1, 32'h100, 4'hF}) begin
        mismatched++; $display("FAIL ws_hold[%0d]: read=%b addr=%h be=%h want 1/100/f",
                               i, bus.mem_read, bus.mem_address, bus.mem_byteenable);
      end
      if (i == 3) begin bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'h2442_0001; end
      step();
    end
    exp_stall = sat_add(exp_stall, 3);
    compared++;
    if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data} !== {1'b1, 1'b0, 32'h2442_0001}) begin
      mismatched++; $display("FAIL ws_rsp: valid=%b err=%b data=%h want 1/0/24420001", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data);
    end
    compared++;
    if (stall_count !== CW'(exp_stall)) begin mismatched++; $display("FAIL ws_stall: got %0d want %0d", stall_count, exp_stall); end
  endtask

  // Entered with a response pending from test_wait_states.
  task automatic test_back_to_back();
    cpu_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, bus.mem_read} !== {1'b1, 1'b0, 32'h2442_0001, 1'b0}) begin
        mismatched++; $display("FAIL bp_hold[%0d]: valid=%b err=%b data=%h read=%b want 1/0/24420001/0",
                               i, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, bus.mem_read);
      end
    end
    cpu_rsp_ready = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = 32'h44;
    bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'h3C1D_0010;
    #1;
    compared++;
    if (cpu_req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready: got %b want 1", cpu_req_ready); end
    step();
    cpu_rsp_ready = 1'b0; cpu_req_valid = 1'b0;
    compared++;
    if ({bus.mem_read, bus.mem_address, cpu_rsp_valid, busy} !== {1'b1, 32'h44, 1'b0, 1'b1}) begin
      mismatched++; $display("FAIL b2b_bus: read=%b addr=%h valid=%b busy=%b want 1/44/0/1",
                             bus.mem_read, bus.mem_address, cpu_rsp_valid, busy);
    end
    step();
    compared++;
    if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data} !== {1'b1, 1'b0, 32'h3C1D_0010}) begin
      mismatched++; $display("FAIL b2b_rsp: valid=%b err=%b data=%h want 1/0/3c1d0010", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data);
    end
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h42; bus.mem_readdata = 32'hAAAA_5555;
    step();
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
        mismatched++; $display("FAIL mis_rsp[%0d]: read=%b valid=%b err=%b data=%h want 0/1/1/0",
                               i, bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data);
      end
      step();
    end
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic test_flush_drain();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h200; bus.mem_waitrequest = 1'b1;
    step();
    cpu_req_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    compared++;
    if ({cpu_req_ready, bus.mem_read} !== 2'b01) begin
      mismatched++; $display("FAIL fd_flush: ready=%b read=%b want 0/1", cpu_req_ready, bus.mem_read);
    end
    step();
    flush = 1'b0; cpu_req_valid = 1'b1; cpu_req_addr = 32'h300;
    #1;
    compared++;
    if ({cpu_req_ready, bus.mem_read, bus.mem_address} !== {1'b0, 1'b1, 32'h200}) begin
      mismatched++; $display("FAIL fd_drain1: ready=%b read=%b addr=%h want 0/1/200", cpu_req_ready, bus.mem_read, bus.mem_address);
    end
    step();
    compared++;
    if ({cpu_req_ready, bus.mem_read, bus.mem_address, cpu_rsp_valid} !== {1'b0, 1'b1, 32'h200, 1'b0}) begin
      mismatched++; $display("FAIL fd_drain2: ready=%b read=%b addr=%h valid=%b want 0/1/200/0",
                             cpu_req_ready, bus.mem_read, bus.mem_address, cpu_rsp_valid);
    end
    cpu_req_valid = 1'b0; bus.mem_waitrequest = 1'b0;
    step();
    exp_stall = sat_add(exp_stall, 3);
    compared++;
    if ({bus.mem_read, cpu_rsp_valid, busy} !== 3'b000) begin
      mismatched++; $display("FAIL fd_idle: read=%b valid=%b busy=%b want 0/0/0", bus.mem_read, cpu_rsp_valid, busy);
    end
    compared++;
    if (stall_count !== CW'(exp_stall)) begin mismatched++; $display("FAIL fd_stall: got %0d want %0d", stall_count, exp_stall); end
  endtask

  task automatic test_flush_misc();
    flush = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = 32'h10;
    #1;
    compared++;
    if (cpu_req_ready !== 1'b0) begin mismatched++; $display("FAIL fi_ready: got %b want 0", cpu_req_ready); end
    step();
    flush = 1'b0; cpu_req_valid = 1'b0;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL fi_busy: got %b want 0", busy); end
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h20; bus.mem_waitrequest = 1'b0;
    step();
    cpu_req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    compared++;
    if ({bus.mem_read, cpu_rsp_valid, busy} !== 3'b000) begin
      mismatched++; $display("FAIL fr_drop: read=%b valid=%b busy=%b want 0/0/0", bus.mem_read, cpu_rsp_valid, busy);
    end
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h21;
    step();
    cpu_req_valid = 1'b0; flush = 1'b1; cpu_rsp_ready = 1'b1;
    #1;
    compared++;
    if ({cpu_rsp_valid, cpu_req_ready} !== 2'b10) begin
      mismatched++; $display("FAIL fp_ready: valid=%b ready=%b want 1/0", cpu_rsp_valid, cpu_req_ready);
    end
    step();
    flush = 1'b0; cpu_rsp_ready = 1'b0;
    compared++;
    if ({cpu_rsp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL fp_drop: valid=%b busy=%b want 0/0", cpu_rsp_valid, busy); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp_data;
    logic        mis;
    int          waits, dly;
    bit          b2b;
    a = $urandom & 32'hFFFF_FFFC;
    for (int t = 0; t < 150; t++) begin
      mis      = (a[1:0] != 2'b00);
      exp_data = mis ? 32'h0 : mem_word(a);
      waits    = $urandom_range(0, 3);
      dly      = $urandom_range(0, 3);
      cpu_req_valid = 1'b1; cpu_req_addr = a;
      #1;
      compared++;
      if (cpu_req_ready !== 1'b1) begin mismatched++; $display("FAIL rnd_ready[%0d]: got %b want 1", t, cpu_req_ready); end
      step();
      cpu_req_valid = 1'b0; cpu_rsp_ready = 1'b0;
      if (!mis) begin
        for (int w = 0; w <= waits; w++) begin
          compared++;
          if ({bus.mem_read, bus.mem_address, bus.mem_byteenable, cpu_rsp_valid} !== {1'b1, a, 4'hF, 1'b0}) begin
            mismatched++; $display("FAIL rnd_bus[%0d.%0d]: read=%b addr=%h be=%h valid=%b want 1/%h/f/0",
                                   t, w, bus.mem_read, bus.mem_address, bus.mem_byteenable, cpu_rsp_valid, a);
          end
          if (w == waits) begin bus.mem_waitrequest = 1'b0; bus.mem_readdata = mem_word(a); end
          else begin bus.mem_waitrequest = 1'b1; bus.mem_readdata = $urandom; end
          step();
        end
        exp_stall = sat_add(exp_stall, waits);
        bus.mem_readdata = $urandom;
      end
      for (int d = 0; d <= dly; d++) begin
        compared++;
        if ({bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data} !== {1'b0, 1'b1, mis, exp_data}) begin
          mismatched++; $display("FAIL rnd_rsp[%0d.%0d]: read=%b valid=%b err=%b data=%h want 0/1/%b/%h",
                                 t, d, bus.mem_read, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, mis, exp_data);
        end
        if (d < dly) step();
      end
      compared++;
      if (stall_count !== CW'(exp_stall)) begin mismatched++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", t, stall_count, exp_stall); end
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      b2b = (t != 149) && ($urandom_range(0, 1) == 1);
      cpu_rsp_ready = 1'b1;
      if (!b2b) begin
        step();
        cpu_rsp_ready = 1'b0;
        compared++;
        if ({cpu_rsp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL rnd_done[%0d]: valid=%b busy=%b want 0/0", t, cpu_rsp_valid, busy); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h400; bus.mem_waitrequest = 1'b1;
    step();
    cpu_req_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    exp_stall = 0;
    compared++;
    if ({bus.mem_read, bus.mem_byteenable, cpu_rsp_valid, busy, stall_count} !== '0) begin
      mismatched++; $display("FAIL rm_async: read=%b be=%h valid=%b busy=%b stall=%0d want all 0",
                             bus.mem_read, bus.mem_byteenable, cpu_rsp_valid, busy, stall_count);
    end
    #3 rst_n = 1'b1;
    bus.mem_waitrequest = 1'b0;
    step();
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0; bus.mem_readdata = 32'h0BAD_F00D;
    step();
    cpu_req_valid = 1'b0;
    compared++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h0}) begin
      mismatched++; $display("FAIL rm_bus: read=%b addr=%h want 1/0", bus.mem_read, bus.mem_address);
    end
    step();
    compared++;
    if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, stall_count} !== {1'b1, 1'b0, 32'h0BAD_F00D, CW'(0)}) begin
      mismatched++; $display("FAIL rm_rsp: valid=%b err=%b data=%h stall=%0d want 1/0/0badf00d/0",
                             cpu_rsp_valid, cpu_rsp_err, cpu_rsp_data, stall_count);
    end
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_misaligned();
    test_flush_drain();
    test_flush_misc();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
